// File: rtl/sprite_store.sv
// Double-buffered sprite pixel store.
// The renderer reads the front bank through a registered read port. The loader
// fills the back bank pixel by pixel in row-major order. A completed image waits
// in PEND and becomes the front bank only at a frame boundary, so the renderer
// never shows a half-written sprite.
module sprite_store #(
   parameter int WIDTH     = 8,
   parameter int HEIGHT    = 8,
   parameter int COLR_BITS = 4,
   parameter int ADDRW     = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 replay,
   input  logic                 load_start,
   input  logic                 wr_valid,
   input  logic [COLR_BITS-1:0] wr_data,
   output logic                 wr_ready,
   input  logic                 frame_end,
   input  logic [ADDRW-1:0]     pos,
   output logic [COLR_BITS-1:0] data_out,
   output logic                 load_done,
   output logic                 swapped,
   output logic                 pending
);

   localparam int DEPTH = WIDTH * HEIGHT;
   // Index width of the bank arrays; the upper address bits are covered by the range checks
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDRW:0]   DEPTH_C = (ADDRW+1)'(DEPTH);
   localparam logic [ADDRW-1:0] LAST_C  = ADDRW'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_PEND,
      S_SWAP
   } state_t;

   state_t                 state_q, state_d;
   logic                   fb_q, fb_d;
   logic [ADDRW-1:0]       wa_q, wa_d;
   logic                   load_done_q, load_done_d;
   logic [COLR_BITS-1:0]   data_out_q;
   logic                   wr_en;

   logic [COLR_BITS-1:0]   bank0 [DEPTH];
   logic [COLR_BITS-1:0]   bank1 [DEPTH];

   // Control registers: state, front-bank select, write address, done pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         fb_q        <= 1'b0;
         wa_q        <= '0;
         load_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fb_q        <= fb_d;
         wa_q        <= wa_d;
         load_done_q <= load_done_d;
      end
   end

   // Next-state logic; replay overrides everything but leaves the bank select alone
   always_comb begin
      state_d     = state_q;
      fb_d        = fb_q;
      wa_d        = wa_q;
      load_done_d = 1'b0;
      wr_en       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (load_start) begin
               state_d = S_LOAD;
               wa_d    = '0;
            end
         end
         S_LOAD: begin
            if (wr_valid) begin
               wr_en = 1'b1;
               if (wa_q == LAST_C) begin
                  state_d     = S_PEND;
                  wa_d        = '0;
                  load_done_d = 1'b1;
               end else begin
                  wa_d = wa_q + 1'b1;
               end
            end
         end
         S_PEND: begin
            // A fresh load discards the waiting image, even on a frame boundary
            if (load_start) begin
               state_d = S_LOAD;
               wa_d    = '0;
            end else if (frame_end) begin
               state_d = S_SWAP;
            end
         end
         S_SWAP: begin
            fb_d    = ~fb_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (replay) begin
         state_d     = S_IDLE;
         fb_d        = fb_q;
         wa_d        = '0;
         load_done_d = 1'b0;
         wr_en       = 1'b0;
      end
   end

   // Back-bank pixel write; bank contents survive reset and replay
   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (fb_q) bank0[wa_q[IW-1:0]] <= wr_data;
         else      bank1[wa_q[IW-1:0]] <= wr_data;
      end
   end

   // Registered front-bank read; addresses beyond the sprite read as transparent zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out_q <= '0;
      end else if ({1'b0, pos} < DEPTH_C) begin
         data_out_q <= fb_q ? bank1[pos[IW-1:0]] : bank0[pos[IW-1:0]];
      end else begin
         data_out_q <= '0;
      end
   end

   assign wr_ready  = (state_q == S_LOAD);
   assign pending   = (state_q == S_PEND);
   assign swapped   = (state_q == S_SWAP);
   assign load_done = load_done_q;
   assign data_out  = data_out_q;

endmodule
